branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Fetch-side program counter stage, directly downstream of the ALU.
- Consumes the ALU's combinational jumpFlag (asserted on BLQZ when the operand is <= 0) and the instruction's branch-target index.
- Produces the next instruction address for instruction memory.
- Holds a writable branch-target lookup table, a run/halt state machine, stall handling and a saturating cycle counter for program timing.

Parameters:
- PC_W, 10, program counter width in bits; address space 0..2^PC_W-1.
- LUT_AW, 4, branch LUT index width; LUT holds 2^LUT_AW absolute targets.
- START_ADDR, 0, PC value loaded on start.
- CNT_W, 16, cycle counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin/restart program execution (level, sampled on clk).
- stall  input  1  freeze PC and counter this cycle.
- jumpFlag  input  1  branch-taken from ALU, same-cycle combinational.
- branch_idx  input  LUT_AW  LUT index from the current instruction.
- halt_instr  input  1  current instruction is the halt/done opcode.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  LUT_AW  LUT write index.
- lut_wdata  input  PC_W  LUT write data (absolute target).
- pc  output  PC_W  current instruction address.
- running  output  1  high in RUN state.
- done  output  1  high in HALTED state.
- cycle_count  output  CNT_W  instructions retired since start, saturating.

Behaviour:
- Reset is asynchronous on reset_n low, taking effect immediately, including mid-program:
  - pc=0, state=IDLE, running=0, done=0, cycle_count=0.
  - All LUT entries = 0.
- Release of reset is synchronous to clk; first active edge occurs after reset_n is high.
- States: IDLE, RUN, HALTED. All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> RUN, pc<=START_ADDR, cycle_count<=0.
  - Otherwise hold.
- RUN, evaluated each rising edge in this priority order:
  1. start=1 -> ignored (no restart from RUN).
  2. stall=1 -> pc, cycle_count, state hold. jumpFlag and halt_instr are ignored.
  3. halt_instr=1 -> HALTED, pc holds, cycle_count increments by 1. Halt wins over a simultaneous jumpFlag.
  4. jumpFlag=1 -> pc<=LUT[branch_idx], cycle_count+1.
  5. Otherwise pc<=pc+1, wrapping 2^PC_W-1 -> 0 with no flag; cycle_count+1.
- HALTED:
  - done=1, pc holds.
  - start=1 -> RUN, pc<=START_ADDR, cycle_count<=0, done<=0 on that edge.
- Latency: a branch decision at edge N is visible on pc after edge N (one cycle), so there is a single-cycle fetch loop.
- cycle_count saturates at 2^CNT_W-1 and does not wrap.
- LUT:
  - Synchronous write on the rising edge when lut_we=1, allowed in any state.
  - Read is combinational, indexed by branch_idx.
  - Write and branch to the same index on the same edge: pc takes the OLD entry; the new value applies from the next cycle.
- jumpFlag/branch_idx/halt_instr are don't-care outside RUN.
- X on jumpFlag while RUN and stall=0 is a protocol violation; the bench flags it.

Test Plan:
- Reset, load LUT[3]=0x050, start pulse, no branches for 4 cycles -> pc 0,1,2,3,4; running=1; cycle_count=4.
- In RUN at pc=0x012, branch_idx=3, jumpFlag=1 for one cycle -> next pc=0x050, then 0x051; cycle_count increments each edge.
- stall=1 for 3 cycles with jumpFlag=1 at pc=0x020 -> pc stays 0x020, cycle_count unchanged; on release with jumpFlag=0, pc=0x021.
- halt_instr=1 and jumpFlag=1 same edge at pc=0x030 -> done=1, running=0, pc stays 0x030. Later start=1 -> pc=0x000, cycle_count=0, done=0.
- pc=0x3FF with no branch -> pc wraps to 0x000. Same edge: lut_we=1 to index 5 with 0x100 while branching via index 5 (old value 0x0AA) -> pc=0x0AA; next branch via 5 -> 0x100.
- reset_n low mid-RUN, asynchronously between edges -> pc=0, state IDLE, done=0, cycle_count=0 immediately; LUT reads 0 after release.

Source files
------------

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch-side program counter with branch LUT, run/halt FSM and cycle counter
module branch_pc_unit #(
  parameter int PC_W       = 10,
  parameter int LUT_AW     = 4,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              jumpFlag,
  input  logic [LUT_AW-1:0] branch_idx,
  input  logic              halt_instr,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   lut [LUT_DEPTH];
  logic [PC_W-1:0]   branch_target;
  logic [CNT_W-1:0]  cnt_inc;

  // Combinational LUT read; a same-edge write is only seen from the next cycle.
  assign branch_target = lut[branch_idx];

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);

  // Status outputs are pure decodes of the state register.
  assign running = (state == RUN);
  assign done    = (state == HALTED);

  // Branch-target table: cleared on reset, writable in any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Run/halt FSM with PC and cycle counter; start is ignored while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_PC;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            cycle_count <= cnt_inc;
            if (halt_instr) begin
              state <= HALTED;
            end else if (jumpFlag) begin
              pc <= branch_target;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard testbench for branch_pc_unit
module tb_branch_pc_unit;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, stall, jumpFlag, halt_instr, lut_we;
  logic [LUT_AW-1:0] branch_idx, lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              running, done;
  logic [CW-1:0]     cycle_count;

  typedef struct {
    string           name;
    logic [PC_W-1:0] pc;
    logic            run;
    logic            dn;
    logic [CW-1:0]   cnt;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int total = 0;
  int bad   = 0;

  branch_pc_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_ADDR(0), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .jumpFlag(jumpFlag),
    .branch_idx(branch_idx), .halt_instr(halt_instr), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc), .running(running),
    .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Protocol watch: jumpFlag must be known whenever it can steer the PC.
  always @(posedge clk) begin
    if (reset_n === 1'b1 && running === 1'b1 && stall === 1'b0 && $isunknown(jumpFlag)) begin
      bad++;
      $display("FAIL jumpflag_x: jumpFlag=%b while running, required known value", jumpFlag);
    end
  end

  // Drive one cycle of stimulus, queue the expected post-edge state, capture the observed state.
  task automatic apply(input string nm, input logic st, input logic stl, input logic jf,
                       input logic [LUT_AW-1:0] idx, input logic hl, input logic we,
                       input logic [LUT_AW-1:0] wa, input logic [PC_W-1:0] wd,
                       input logic [PC_W-1:0] epc, input logic erun, input logic edn,
                       input logic [CW-1:0] ecnt);
    snap_t e, o;
    @(negedge clk);
    start = st; stall = stl; jumpFlag = jf; branch_idx = idx; halt_instr = hl;
    lut_we = we; lut_waddr = wa; lut_wdata = wd;
    e.name = nm; e.pc = epc; e.run = erun; e.dn = edn; e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.name = nm; o.pc = pc; o.run = running; o.dn = done; o.cnt = cycle_count;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    snap_t e, o;
    reset_n = 1'b0;
    start = 0; stall = 0; jumpFlag = 0; branch_idx = 0; halt_instr = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;
    #1;
    e.name = "reset"; e.pc = '0; e.run = 0; e.dn = 0; e.cnt = '0;
    exp_q.push_back(e);
    o.name = "reset"; o.pc = pc; o.run = running; o.dn = done; o.cnt = cycle_count;
    obs_q.push_back(o);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    snap_t e, o;
    apply("idle_lut1", 0, 0, 0, 0, 0, 1, 4'd1, 10'h012, 10'h000, 0, 0, 0);
    apply("idle_lut2", 0, 0, 0, 0, 0, 1, 4'd2, 10'h020, 10'h000, 0, 0, 0);
    apply("idle_lut3", 0, 0, 0, 0, 0, 1, 4'd3, 10'h050, 10'h000, 0, 0, 0);
    apply("idle_lut4", 0, 0, 0, 0, 0, 1, 4'd4, 10'h030, 10'h000, 0, 0, 0);
    apply("idle_lut5", 0, 0, 1, 4'd3, 0, 1, 4'd5, 10'h0AA, 10'h000, 0, 0, 0);
    apply("idle_lut6", 0, 0, 0, 0, 0, 1, 4'd6, 10'h3FE, 10'h000, 0, 0, 0);
    apply("start", 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      apply("seq", 0, 0, 0, 0, 0, 0, 0, 0, PC_W'(k), 1, 0, CW'(k));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    snap_t e, o;
    apply("br_to_012", 0, 0, 1, 4'd1, 0, 0, 0, 0, 10'h012, 1, 0, 5);
    apply("br_to_050", 0, 0, 1, 4'd3, 0, 0, 0, 0, 10'h050, 1, 0, 6);
    apply("after_br",  0, 0, 0, 4'd3, 0, 0, 0, 0, 10'h051, 1, 0, 7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_stall();
    snap_t e, o;
    apply("br_to_020", 0, 0, 1, 4'd2, 0, 0, 0, 0, 10'h020, 1, 0, 8);
    apply("stall1", 0, 1, 1, 4'd3, 0, 0, 0, 0, 10'h020, 1, 0, 8);
    apply("stall2", 0, 1, 1, 4'd3, 1, 0, 0, 0, 10'h020, 1, 0, 8);
    apply("stall3", 0, 1, 1, 4'd3, 0, 0, 0, 0, 10'h020, 1, 0, 8);
    apply("unstall", 0, 0, 0, 4'd3, 0, 0, 0, 0, 10'h021, 1, 0, 9);
    apply("start_in_run", 1, 0, 0, 4'd3, 0, 0, 0, 0, 10'h022, 1, 0, 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    snap_t e, o;
    apply("br_to_030", 0, 0, 1, 4'd4, 0, 0, 0, 0, 10'h030, 1, 0, 11);
    apply("halt_jump", 0, 0, 1, 4'd3, 1, 0, 0, 0, 10'h030, 0, 1, 12);
    apply("halted_hold", 0, 0, 1, 4'd3, 0, 0, 0, 0, 10'h030, 0, 1, 12);
    apply("restart", 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_wrap_lut_collision();
    snap_t e, o;
    apply("br_to_3fe", 0, 0, 1, 4'd6, 0, 0, 0, 0, 10'h3FE, 1, 0, 1);
    apply("to_3ff",    0, 0, 0, 4'd6, 0, 0, 0, 0, 10'h3FF, 1, 0, 2);
    apply("wrap",      0, 0, 0, 4'd6, 0, 0, 0, 0, 10'h000, 1, 0, 3);
    apply("wr_br_old", 0, 0, 1, 4'd5, 0, 1, 4'd5, 10'h100, 10'h0AA, 1, 0, 4);
    apply("br_new",    0, 0, 1, 4'd5, 0, 0, 0, 0, 10'h100, 1, 0, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    snap_t e, o;
    for (int k = 1; k <= 14; k++) begin
      apply("saturate", 0, 0, 0, 0, 0, 0, 0, 0, PC_W'(10'h100 + k), 1, 0,
            CW'((5 + k > 15) ? 15 : 5 + k));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    e.name = "async_reset"; e.pc = '0; e.run = 0; e.dn = 0; e.cnt = '0;
    exp_q.push_back(e);
    o.name = "async_reset"; o.pc = pc; o.run = running; o.dn = done; o.cnt = cycle_count;
    obs_q.push_back(o);
    @(negedge clk);
    reset_n = 1'b1;
    apply("post_rst_start", 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 0);
    apply("lut3_cleared",   0, 0, 1, 4'd3, 0, 0, 0, 0, 10'h000, 1, 0, 1);
    apply("post_rst_seq",   0, 0, 0, 4'd3, 0, 0, 0, 0, 10'h001, 1, 0, 2);
    apply("lut5_cleared",   0, 0, 1, 4'd5, 0, 0, 0, 0, 10'h000, 1, 0, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if ({o.pc, o.run, o.dn, o.cnt} !== {e.pc, e.run, e.dn, e.cnt}) begin
        bad++;
        $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, required pc=%h run=%b done=%b cnt=%0d",
                 e.name, o.pc, o.run, o.dn, o.cnt, e.pc, e.run, e.dn, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_wrap_lut_collision();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
